crono_countdown_ctrl: RTL
=========================

CRONO_COUNTDOWN_CTRL -- requirements
Module: crono_countdown_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000: clk cycles per countdown second; minimum 2.
REQ-002 SHALL have parameter RING_SECS, default 10: ring duration in seconds, used only with the Configuration macro.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port Reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port prog_i  input  1  one-cycle pulse: enter programming.
REQ-006 SHALL have port start_i  input  1  one-cycle pulse: start/resume countdown.
REQ-007 SHALL have port stop_i  input  1  one-cycle pulse: pause countdown.
REQ-008 SHALL have port ack_i  input  1  one-cycle pulse: acknowledge ring.
REQ-009 SHALL have port field_i  input  2  field to edit: 0=ss, 1=mm, 2=hh, 3=none.
REQ-010 SHALL have port inc_i  input  1  one-cycle pulse: increment selected field.
REQ-011 SHALL have port dec_i  input  1  one-cycle pulse: decrement selected field.
REQ-012 SHALL have ports hh_o, mm_o, ss_o  output  8 each  packed-BCD remaining time.
REQ-013 SHALL have port crono_activo_o  output  1  high only in RUN.
REQ-014 SHALL have port ring_o  output  1  high only in DONE.
REQ-015 SHALL have port state_o  output  2  encoding PROG=0, IDLE=1, RUN=2, DONE=3.

Function
REQ-016 SHALL implement FSM states PROG, IDLE, RUN, DONE. All outputs are registered; a pulse in cycle N is reflected on outputs in cycle N+1.
REQ-017 PROG: inc_i/dec_i edit the field selected by field_i; start_i -> RUN if time nonzero, else stays PROG; stop_i -> IDLE.
REQ-018 IDLE: start_i -> RUN if time nonzero, else ignored; prog_i -> PROG.
REQ-019 RUN: stop_i -> IDLE, holding time and prescaler value; prog_i -> PROG.
REQ-020 DONE: ack_i or prog_i -> PROG, time remains 00:00:00.
REQ-021 Priority for simultaneous pulses: prog_i > stop_i > start_i > ack_i; inc_i and dec_i both high -> no edit.
REQ-022 inc/dec are ignored outside PROG and when field_i=3.
REQ-023 Edit wrap: ss and mm 59<->00, hh 23<->00; no carry between fields during edit.
REQ-024 Prescaler SHALL clear on PROG->RUN entry; first decrement occurs exactly TICK_DIV cycles after the start_i cycle. IDLE->RUN resumes from the held prescaler value.
REQ-025 Each prescaler terminal count in RUN decrements the time by one second: ss 00->59 borrows mm; mm 00->59 borrows hh.
REQ-026 The decrement reaching 00:00:00 SHALL enter DONE in the same clock; ring_o rises on the next cycle, crono_activo_o falls.
REQ-027 Every BCD digit SHALL stay legal (tens 0-5 for mm/ss, hh 00-23) under all sequences.

Reset
REQ-028 Reset asserted SHALL force state PROG, time 00:00:00, prescaler 0, crono_activo_o=0, ring_o=0, state_o=0 immediately, including mid-RUN or DONE.
REQ-029 After Reset release, no transition SHALL occur without a new input pulse.

Configuration
REQ-030 Macro CRONO_RING_TIMEOUT_EN defined: DONE SHALL return to PROG automatically after RING_SECS prescaler periods if no ack_i, ring_o falling with the transition.
REQ-031 Macro CRONO_RING_TIMEOUT_EN undefined: DONE SHALL persist until ack_i, prog_i or Reset; RING_SECS unused.

Verification (TICK_DIV=4, RING_SECS=3)
REQ-032 Reset, field 0, inc x3, start -> state RUN; ss 03,02,01,00 at 4-cycle spacing; ring_o=1 one cycle after 00.
REQ-033 Program 01:00:00, start, run 4 cycles -> 00:59:59; 8 more cycles -> 00:59:57.
REQ-034 In PROG field 0 at 00, dec -> ss=59; field 2 at 23, inc -> hh=00; mm unchanged.
REQ-035 Program ss=05, start, stop after 6 cycles, wait 20, start -> time 00:00:04 held during pause; next decrement 2 cycles after resume.
REQ-036 Start with 00:00:00 -> stays PROG, crono_activo_o=0; prog_i and start_i same cycle in IDLE -> PROG.
REQ-037 DONE with macro -> PROG after 12 cycles, ring_o=0; without macro -> ring_o held 50 cycles until ack_i; Reset mid-RUN -> all outputs zero immediately.

Source files
------------

// File: rtl/crono_countdown_ctrl.sv
// Countdown timer controller: hh:mm:ss programming, countdown with a prescaler, ring on expiry.
// Optional macro CRONO_RING_TIMEOUT_EN makes DONE fall back to PROG after RING_SECS seconds.
//
// state | meaning
// PROG  | editing hh/mm/ss with inc/dec, countdown stopped
// IDLE  | paused, time and prescaler held
// RUN   | counting down one second per TICK_DIV clocks
// DONE  | reached 00:00:00, ringing

module crono_countdown_ctrl #(
  parameter int TICK_DIV  = 100000000,
  parameter int RING_SECS = 10
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       prog_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       ack_i,
  input  logic [1:0] field_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [7:0] hh_o,
  output logic [7:0] mm_o,
  output logic [7:0] ss_o,
  output logic       crono_activo_o,
  output logic       ring_o,
  output logic [1:0] state_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {PROG = 2'd0, IDLE = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          tick;
  logic          time_nz;
  logic          last_sec;
  logic          edit_en;
  logic [7:0]    ss_dn, mm_dn, hh_dn;

  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] maxv,
                                          input logic up);
    if (up) begin
      if (v == maxv) return 8'h00;
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return v + 8'd1;
    end
    if (v == 8'h00) return maxv;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return v - 8'd1;
  endfunction

  assign tick     = (presc == PRESC_LAST);
  assign time_nz  = |{hh_o, mm_o, ss_o};
  assign last_sec = (hh_o == 8'h00) && (mm_o == 8'h00) && (ss_o == 8'h01);
  assign edit_en  = inc_i ^ dec_i;
  assign state_o  = state;

  // One-second borrow chain; never evaluated at 00:00:00 because RUN needs nonzero time.
  always_comb begin
    ss_dn = bcd_step(ss_o, 8'h59, 1'b0);
    mm_dn = mm_o;
    hh_dn = hh_o;
    if (ss_o == 8'h00) begin
      mm_dn = bcd_step(mm_o, 8'h59, 1'b0);
      if (mm_o == 8'h00) hh_dn = bcd_step(hh_o, 8'h23, 1'b0);
    end
  end

`ifdef CRONO_RING_TIMEOUT_EN
  localparam int RW = $clog2(RING_SECS + 1);
  logic [RW-1:0] ring_cnt;
`else
  logic [31:0] ring_secs_unused;
  assign ring_secs_unused = RING_SECS;
`endif

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state          <= PROG;
      presc          <= '0;
      hh_o           <= 8'h00;
      mm_o           <= 8'h00;
      ss_o           <= 8'h00;
      crono_activo_o <= 1'b0;
      ring_o         <= 1'b0;
`ifdef CRONO_RING_TIMEOUT_EN
      ring_cnt       <= '0;
`endif
    end else begin
      case (state)
        PROG: begin
          if (!prog_i && stop_i) begin
            state <= IDLE;
          end else if (!prog_i && start_i) begin
            if (time_nz) begin
              state          <= RUN;
              presc          <= '0;
              crono_activo_o <= 1'b1;
            end
          end else if (edit_en) begin
            case (field_i)
              2'd0:    ss_o <= bcd_step(ss_o, 8'h59, inc_i);
              2'd1:    mm_o <= bcd_step(mm_o, 8'h59, inc_i);
              2'd2:    hh_o <= bcd_step(hh_o, 8'h23, inc_i);
              default: ;
            endcase
          end
        end
        IDLE: begin
          if (prog_i) begin
            state <= PROG;
          end else if (!stop_i && start_i && time_nz) begin
            state          <= RUN;
            crono_activo_o <= 1'b1;
          end
        end
        RUN: begin
          if (prog_i) begin
            state          <= PROG;
            crono_activo_o <= 1'b0;
          end else begin
            // Prescaler keeps advancing in the stop cycle so a resume continues the same second.
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
              ss_o <= ss_dn;
              mm_o <= mm_dn;
              hh_o <= hh_dn;
            end
            if (tick && last_sec) begin
              state          <= DONE;
              crono_activo_o <= 1'b0;
              ring_o         <= 1'b1;
`ifdef CRONO_RING_TIMEOUT_EN
              ring_cnt       <= RW'(RING_SECS);
`endif
            end else if (stop_i) begin
              state          <= IDLE;
              crono_activo_o <= 1'b0;
            end
          end
        end
        DONE: begin
          if (prog_i || ack_i) begin
            state  <= PROG;
            ring_o <= 1'b0;
          end else begin
`ifdef CRONO_RING_TIMEOUT_EN
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
              if (ring_cnt == RW'(1)) begin
                state  <= PROG;
                ring_o <= 1'b0;
              end else begin
                ring_cnt <= ring_cnt - RW'(1);
              end
            end
`endif
          end
        end
        default: state <= PROG;
      endcase
    end
  end

endmodule
